// File: rtl/regfile_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_fifo_ctrl_pkg
// Shared definitions for the register-file-backed FIFO controller and the
// register file it drives: default data/address widths, queue depth, pointer
// and count widths, and small sizing helpers.
// -----------------------------------------------------------------------------
package regfile_fifo_ctrl_pkg;

    // Defaults shared with the 2R/1W register file instance.
    localparam int RF_DATA_WIDTH = 4;
    localparam int RF_ADDR_N     = 3;
    localparam int SCAN_DIV_DEF  = 4;

    // Queue geometry for the default register file.
    localparam int DEPTH = 2 ** RF_ADDR_N;
    localparam int PTR_W = RF_ADDR_N;
    localparam int CNT_W = RF_ADDR_N + 1;

    // Width of a counter that must hold 0..div-1; never narrower than 1 bit.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/regfile_fifo_ctrl_edge_pulse.sv
// -----------------------------------------------------------------------------
// edge_pulse
// One-cycle rising-edge detector for a level input already synchronous to clk.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset (clears the history flop)
//   level_i  - input level
//   pulse_o  - high for the cycle in which level_i is high and was low before
// Because the history flop resets to 0, a level held high across reset
// release produces exactly one pulse in the first cycle after release.
// -----------------------------------------------------------------------------
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/regfile_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_fifo_ctrl
// Turns an external 2-read/1-write register file into a circular FIFO of
// 2**addressN entries. The write port carries enqueues (at the tail), read
// port 0 carries dequeues (from the head), and read port 1 walks a slowly
// advancing scan address so a display can show which entries are occupied.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   enq_i, deq_i   - request levels; one operation per rising edge
//   din_i          - word to enqueue (sampled in the enq edge cycle)
//   dout_o         - last dequeued word, registered
//   full_o/empty_o - flags decoded from the registered count
//   count_o        - number of occupied entries
//   rf_we_o/rf_wa_o/rf_wd_o - register file write port
//   rf_ra0_o/rf_rd0_i       - register file read port 0 (head)
//   rf_ra1_o       - register file read port 1 address (scan pointer)
//   scan_valid_o   - entry at rf_ra1_o currently holds queued data
// -----------------------------------------------------------------------------
module regfile_fifo_ctrl
    import regfile_fifo_ctrl_pkg::*;
#(
    parameter int dataWidth = RF_DATA_WIDTH,
    parameter int addressN  = RF_ADDR_N,
    parameter int scanDiv   = SCAN_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enq_i,
    input  logic                 deq_i,
    input  logic [dataWidth-1:0] din_i,
    output logic [dataWidth-1:0] dout_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [addressN:0]    count_o,
    output logic                 rf_we_o,
    output logic [addressN-1:0]  rf_wa_o,
    output logic [dataWidth-1:0] rf_wd_o,
    output logic [addressN-1:0]  rf_ra0_o,
    input  logic [dataWidth-1:0] rf_rd0_i,
    output logic [addressN-1:0]  rf_ra1_o,
    output logic                 scan_valid_o
);

    localparam logic [addressN:0] FULL_CNT = (addressN + 1)'(2 ** addressN);
    localparam int                DIV_W    = div_width(scanDiv);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(scanDiv - 1);

    logic                 enq_p, deq_p;
    logic                 enq_ok, deq_ok;
    logic [addressN-1:0]  head_q, head_d;
    logic [addressN-1:0]  tail_q, tail_d;
    logic [addressN:0]    count_q, count_d;
    logic [dataWidth-1:0] dout_q, dout_d;
    logic [addressN-1:0]  scan_q, scan_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [addressN-1:0]  scan_off;

    edge_pulse u_enq_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (enq_i),
        .pulse_o (enq_p)
    );

    edge_pulse u_deq_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (deq_i),
        .pulse_o (deq_p)
    );

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

    // A dequeue on full frees the slot the enqueue writes into in the same
    // cycle; the read is combinational so the old word is captured first.
    assign deq_ok = deq_p & ~empty_o;
    assign enq_ok = enq_p & (~full_o | deq_ok);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (enq_ok) begin
            tail_d = tail_q + 1'b1;
        end
        if (deq_ok) begin
            head_d = head_q + 1'b1;
            dout_d = rf_rd0_i;
        end
        case ({enq_ok, deq_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Scan pointer advances once every scanDiv clocks.
    always_comb begin
        scan_d = scan_q;
        div_d  = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            scan_d = scan_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            scan_q  <= '0;
            div_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            scan_q  <= scan_d;
            div_q   <= div_d;
        end
    end

    // Distance from head, modulo depth, tells whether the scanned slot lies
    // inside the occupied window [head, head+count).
    assign scan_off     = scan_q - head_q;
    assign scan_valid_o = ({1'b0, scan_off} < count_q);

    assign dout_o   = dout_q;
    assign count_o  = count_q;
    assign rf_we_o  = enq_ok;
    assign rf_wa_o  = tail_q;
    assign rf_wd_o  = din_i;
    assign rf_ra0_o = head_q;
    assign rf_ra1_o = scan_q;

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_fifo_ctrl
// Directed bench for regfile_fifo_ctrl with a behavioural 2R/1W register file.
// -----------------------------------------------------------------------------
module tb_regfile_fifo_ctrl;
    import regfile_fifo_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enq, deq;
    logic [3:0]       din, dout;
    logic             full, empty;
    logic [CNT_W-1:0] count;
    logic             rf_we;
    logic [PTR_W-1:0] rf_wa, rf_ra0, rf_ra1;
    logic [3:0]       rf_wd, rf_rd0;
    logic             scan_valid;

    logic [3:0] rf_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [3:0]       model_q [$];
    logic [PTR_W-1:0] exp_head, exp_tail;
    logic [3:0]       last_dout;

    always #5 clk = ~clk;

    regfile_fifo_ctrl #(.dataWidth(4), .addressN(3), .scanDiv(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enq_i        (enq),
        .deq_i        (deq),
        .din_i        (din),
        .dout_o       (dout),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .rf_we_o      (rf_we),
        .rf_wa_o      (rf_wa),
        .rf_wd_o      (rf_wd),
        .rf_ra0_o     (rf_ra0),
        .rf_rd0_i     (rf_rd0),
        .rf_ra1_o     (rf_ra1),
        .scan_valid_o (scan_valid)
    );

    // Register file model: combinational read, write committed on posedge.
    initial begin
        for (int i = 0; i < DEPTH; i++) rf_mem[i] = 4'h0;
    end
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_wa] <= rf_wd;
    end
    assign rf_rd0 = rf_mem[rf_ra0];

    // Posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int exp_count);
        check_eq({tag, "_count"}, 32'(count), 32'(exp_count));
        check_eq({tag, "_empty"}, 32'(empty), 32'(exp_count == 0));
        check_eq({tag, "_full"},  32'(full),  32'(exp_count == DEPTH));
    endtask

    task automatic model_clear();
        model_q.delete();
        exp_head  = '0;
        exp_tail  = '0;
        last_dout = 4'h0;
    endtask

    // Reset pulse spanning one posedge; inputs keep whatever the caller set.
    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_enq(input logic [3:0] d, input bit ok);
        enq = 1'b1;
        din = d;
        #1;
        check_eq("enq_we", 32'(rf_we), 32'(ok));
        if (ok) begin
            check_eq("enq_wa", 32'(rf_wa), 32'(exp_tail));
            check_eq("enq_wd", 32'(rf_wd), 32'(d));
        end
        step();
        enq = 1'b0;
        step();
        if (ok) begin
            model_q.push_back(d);
            exp_tail = exp_tail + 1'b1;
        end
        $display("[TB] enq din=%0h accepted=%0d count=%0d", d, ok, count);
    endtask

    task automatic do_deq(input bit ok);
        deq = 1'b1;
        #1;
        if (ok) check_eq("deq_ra0", 32'(rf_ra0), 32'(exp_head));
        step();
        if (ok) begin
            last_dout = model_q.pop_front();
            exp_head  = exp_head + 1'b1;
        end
        check_eq("deq_dout", 32'(dout), 32'(last_dout));
        deq = 1'b0;
        step();
        $display("[TB] deq dout=%0h accepted=%0d count=%0d", dout, ok, count);
    endtask

    task automatic do_both(input logic [3:0] d);
        enq = 1'b1;
        deq = 1'b1;
        din = d;
        #1;
        check_eq("both_we",  32'(rf_we),  32'd1);
        check_eq("both_wa",  32'(rf_wa),  32'(exp_tail));
        check_eq("both_ra0", 32'(rf_ra0), 32'(exp_head));
        step();
        last_dout = model_q.pop_front();
        model_q.push_back(d);
        exp_head = exp_head + 1'b1;
        exp_tail = exp_tail + 1'b1;
        check_eq("both_dout", 32'(dout), 32'(last_dout));
        enq = 1'b0;
        deq = 1'b0;
        step();
        $display("[TB] enq+deq din=%0h dout=%0h count=%0d", d, dout, count);
    endtask

    initial begin
        rst_n = 1'b0;
        enq   = 1'b0;
        deq   = 1'b0;
        din   = 4'h0;
        model_clear();

        // Reset state
        #12;
        check_state("rst", 0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_we",   32'(rf_we), 32'd0);
        check_eq("rst_ra1",  32'(rf_ra1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three enqueues then three dequeues
        do_enq(4'h1, 1'b1);
        do_enq(4'h2, 1'b1);
        do_enq(4'h3, 1'b1);
        check_state("enq3", 3);
        do_deq(1'b1);
        check_eq("deq1_val", 32'(dout), 32'd1);
        do_deq(1'b1);
        check_eq("deq2_val", 32'(dout), 32'd2);
        do_deq(1'b1);
        check_eq("deq3_val", 32'(dout), 32'd3);
        check_state("deq3", 0);
        do_deq(1'b0);
        check_eq("deq_empty_hold", 32'(dout), 32'd3);
        check_state("deq_empty", 0);

        // Asynchronous reset mid-sequence with five entries queued
        for (int i = 0; i < 5; i++) do_enq(4'(i + 4), 1'b1);
        check_state("pre_arst", 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_state("arst", 0);
        check_eq("arst_dout", 32'(dout), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full, rejected enqueue, then simultaneous enq/deq on full
        for (int i = 1; i <= 8; i++) do_enq(4'(i), 1'b1);
        check_state("fill8", 8);
        do_enq(4'h9, 1'b0);
        check_state("full_rej", 8);
        do_both(4'hA);
        check_eq("both_old0", 32'(dout), 32'd1);
        check_state("both", 8);
        check_eq("both_head", 32'(rf_ra0), 32'd1);
        check_eq("both_tail", 32'(rf_wa),  32'd1);
        for (int i = 0; i < 8; i++) do_deq(1'b1);
        check_eq("drain_last", 32'(dout), 32'hA);
        check_state("drain", 0);

        // enq held high across reset release -> exactly one enqueue
        enq = 1'b1;
        din = 4'h5;
        apply_reset();
        #1;
        check_eq("held_we", 32'(rf_we), 32'd1);
        check_eq("held_wa", 32'(rf_wa), 32'd0);
        step();
        check_eq("held_we2", 32'(rf_we), 32'd0);
        enq = 1'b0;
        model_q.push_back(4'h5);
        exp_tail = 3'd1;
        step();
        check_state("held", 1);

        // Wrap: ten enqueue/dequeue pairs carry both pointers past 7 -> 0
        for (int i = 0; i < 10; i++) begin
            do_enq(4'(i + 6), 1'b1);
            do_deq(1'b1);
        end
        check_state("wrap", 1);
        check_eq("wrap_head", 32'(rf_ra0), 32'd2);
        check_eq("wrap_tail", 32'(rf_wa),  32'd3);
        check_eq("wrap_dout", 32'(dout),   32'hE);

        // Scan: head=6, count=2 -> only slots 6 and 7 occupied
        apply_reset();
        for (int i = 0; i < 6; i++) do_enq(4'(i), 1'b1);
        for (int i = 0; i < 6; i++) do_deq(1'b1);
        do_enq(4'hC, 1'b1);
        do_enq(4'hD, 1'b1);
        check_state("scan", 2);
        check_eq("scan_head", 32'(rf_ra0), 32'd6);
        for (int i = 0; i < 36; i++) begin
            logic [2:0] exp_ra1;
            exp_ra1 = 3'((cyc / 4) % 8);
            check_eq("scan_ra1",   32'(rf_ra1),     32'(exp_ra1));
            check_eq("scan_valid", 32'(scan_valid), 32'(exp_ra1 == 3'd6 || exp_ra1 == 3'd7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
